// File: rtl/four_by_four_node_patch.sv
// 4x4 patch of a fixed-point 2-D membrane solver: one explicit time step per enabled clock.
// Edge nodes couple to neighbour patches through one boundary value per side.
module four_by_four_node_patch #(
  parameter  int unsigned DAMP_SHIFT = 9,
  localparam int unsigned W          = 18
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                middle,
  input  logic signed [W-1:0] init,
  input  logic signed [W-1:0] rho,
  input  logic signed [W-1:0] u_1_right,
  input  logic signed [W-1:0] u_1_left_1,
  input  logic signed [W-1:0] u_1_up_1,
  input  logic signed [W-1:0] u_1_down_1,
  output logic signed [W-1:0] data_out
);

  localparam int unsigned N   = 4;
  localparam int unsigned NN  = N * N;
  localparam int unsigned AW  = 24;
  localparam int unsigned PW  = W + AW;
  localparam int unsigned SW  = 28;
  localparam int unsigned MW  = W + 4;
  localparam int unsigned MID = N + 1;
  localparam int unsigned FRAC = 17;

  localparam logic signed [SW-1:0] SAT_MAX = SW'(131071);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-131072);

  logic signed [W-1:0]  u_q      [NN];
  logic signed [W-1:0]  u_prev_q [NN];
  logic signed [W-1:0]  u_d      [NN];
  logic signed [W-1:0]  data_out_q;
  logic signed [W-1:0]  data_out_d;
  logic signed [MW-1:0] sum_all;

  // Per-node update: Laplacian coupling plus damped velocity, saturated to 1.17
  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      localparam int unsigned I = r * N + c;

      logic signed [W-1:0]  left_n;
      logic signed [W-1:0]  right_n;
      logic signed [W-1:0]  up_n;
      logic signed [W-1:0]  down_n;
      logic signed [AW-1:0] lap;
      logic signed [AW-1:0] vel;
      logic signed [PW-1:0] prod_full;
      logic signed [SW-1:0] sum;

      if (c == 0) begin : g_l
        assign left_n = u_1_left_1;
      end else begin : g_l
        assign left_n = u_q[I-1];
      end

      if (c == N - 1) begin : g_r
        assign right_n = u_1_right;
      end else begin : g_r
        assign right_n = u_q[I+1];
      end

      if (r == 0) begin : g_u
        assign up_n = u_1_up_1;
      end else begin : g_u
        assign up_n = u_q[I-N];
      end

      if (r == N - 1) begin : g_d
        assign down_n = u_1_down_1;
      end else begin : g_d
        assign down_n = u_q[I+N];
      end

      assign lap       = AW'(left_n) + AW'(right_n) + AW'(up_n) + AW'(down_n)
                       - (AW'(u_q[I]) <<< 2);
      assign vel       = AW'(u_q[I]) - AW'(u_prev_q[I]);
      assign prod_full = PW'(rho) * PW'(lap);
      assign sum       = SW'(u_q[I]) + SW'(vel) - SW'(vel >>> DAMP_SHIFT)
                       + SW'(prod_full >>> FRAC);
      assign u_d[I]    = (sum > SAT_MAX) ? W'(SAT_MAX) :
                         (sum < SAT_MIN) ? W'(SAT_MIN) : W'(sum);
    end
  end

  // Patch mean for the non-tap output mode
  always_comb begin
    sum_all = '0;
    for (int unsigned i = 0; i < NN; i++) begin
      sum_all = sum_all + MW'(u_q[i]);
    end
  end

  assign data_out_d = middle ? u_q[MID] : W'(sum_all >>> 4);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NN; i++) begin
        u_q[i]      <= init;
        u_prev_q[i] <= init;
      end
      data_out_q <= '0;
    end else begin
      if (enable) begin
        for (int unsigned i = 0; i < NN; i++) begin
          u_prev_q[i] <= u_q[i];
          u_q[i]      <= u_d[i];
        end
      end
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_four_by_four_node_patch.sv
// Directed bench for four_by_four_node_patch with hand-computed constants and a
// behavioural node model used for long sequences.
module tb_four_by_four_node_patch;

  localparam int DS = 9;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable;
  logic               middle;
  logic signed [17:0] init;
  logic signed [17:0] rho;
  logic signed [17:0] u_1_right;
  logic signed [17:0] u_1_left_1;
  logic signed [17:0] u_1_up_1;
  logic signed [17:0] u_1_down_1;
  logic signed [17:0] data_out;

  int          checks   = 0;
  int          failures = 0;
  int          mu [4][4];
  int          mp [4][4];
  logic [17:0] m_dout;

  four_by_four_node_patch #(.DAMP_SHIFT(DS)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .middle     (middle),
    .init       (init),
    .rho        (rho),
    .u_1_right  (u_1_right),
    .u_1_left_1 (u_1_left_1),
    .u_1_up_1   (u_1_up_1),
    .u_1_down_1 (u_1_down_1),
    .data_out   (data_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
    end
  endtask

  function automatic longint nb(int r, int c);
    if (c < 0) return longint'(u_1_left_1);
    if (c > 3) return longint'(u_1_right);
    if (r < 0) return longint'(u_1_up_1);
    if (r > 3) return longint'(u_1_down_1);
    return longint'(mu[r][c]);
  endfunction

  task automatic model_step();
    int nu [4][4];
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        longint l, p, v, n;
        l = nb(r, c-1) + nb(r, c+1) + nb(r-1, c) + nb(r+1, c) - 4 * longint'(mu[r][c]);
        p = (longint'(rho) * l) >>> 17;
        v = longint'(mu[r][c]) - longint'(mp[r][c]);
        n = longint'(mu[r][c]) + v - (v >>> DS) + p;
        if (n > 131071) n = 131071;
        else if (n < -131072) n = -131072;
        nu[r][c] = int'(n);
      end
    end
    mp = mu;
    mu = nu;
  endtask

  function automatic logic [17:0] model_out();
    longint s;
    if (middle) return 18'(mu[1][1]);
    s = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s += longint'(mu[r][c]);
    return 18'(s >>> 4);
  endfunction

  // One clock: advance the model with the inputs currently applied, then sample
  task automatic tick();
    logic [17:0] nxt;
    nxt = reset ? 18'h0 : model_out();
    if (reset) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          mu[r][c] = int'(init);
          mp[r][c] = int'(init);
        end
    end else if (enable) begin
      model_step();
    end
    @(posedge clock);
    #1;
    m_dout = nxt;
  endtask

  task automatic set_bnd(input logic [17:0] l, input logic [17:0] r,
                         input logic [17:0] u, input logic [17:0] d);
    u_1_left_1 = l;
    u_1_right  = r;
    u_1_up_1   = u;
    u_1_down_1 = d;
  endtask

  initial begin
    int  peak;
    int  v;
    logic sat_seen;

    // Reset load and hold with enable low
    reset = 1'b1; enable = 1'b0; middle = 1'b0;
    init = 18'h04000; rho = 18'h0;
    set_bnd(18'h0, 18'h0, 18'h0, 18'h0);
    tick();
    check("rst_dout", data_out, 18'h00000);
    reset = 1'b0;
    tick();
    check("load_mean", data_out, 18'h04000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("load_hold", data_out, 18'h04000);
    end
    middle = 1'b1;
    tick();
    check("load_mid", data_out, 18'h04000);

    // Equilibrium: uniform field with matching boundaries never moves
    middle = 1'b0;
    set_bnd(18'h04000, 18'h04000, 18'h04000, 18'h04000);
    rho = 18'h08000; enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("equil", data_out, 18'h04000);
    end

    // Single step driven from the left edge only
    reset = 1'b1; enable = 1'b0; init = 18'h0;
    set_bnd(18'h10000, 18'h0, 18'h0, 18'h0);
    tick();
    check("edge_rst", data_out, 18'h00000);
    reset = 1'b0; enable = 1'b1;
    tick();
    check("edge_pre", data_out, 18'h00000);
    enable = 1'b0;
    tick();
    check("edge_mean", data_out, 18'h01000);
    middle = 1'b1;
    tick();
    check("edge_mid", data_out, 18'h00000);

    // Saturation: corners clamp to +max, interior stays at -1
    reset = 1'b1; init = 18'h20000;
    set_bnd(18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF);
    rho = 18'h1FFFF;
    tick();
    reset = 1'b0; enable = 1'b1;
    tick();
    check("sat_pre", data_out, 18'h20000);
    enable = 1'b0;
    tick();
    check("sat_mid", data_out, 18'h20000);
    middle = 1'b0;
    tick();
    check("sat_mean", data_out, 18'h0FFFE);
    check("sat_model", data_out, m_dout);

    // Enable gating against the reference model, then reset over enable
    reset = 1'b1; init = 18'h0; rho = 18'h08000;
    set_bnd(18'h10000, 18'h0, 18'h0, 18'h0);
    tick();
    reset = 1'b0; enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("gate_run", data_out, m_dout);
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gate_hold", data_out, m_dout);
    end
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("gate_resume", data_out, m_dout);
    end
    reset = 1'b1; init = 18'h04000;
    tick();
    check("rst_pri", data_out, 18'h00000);
    reset = 1'b0; enable = 1'b0;
    tick();
    check("rst_reload", data_out, 18'h04000);

    // Damping: long run with fixed zero boundaries
    reset = 1'b1; init = 18'h10000; rho = 18'h04000;
    set_bnd(18'h0, 18'h0, 18'h0, 18'h0);
    tick();
    reset = 1'b0; enable = 1'b1;
    peak = 0; sat_seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      check("damp", data_out, m_dout);
      if (data_out == 18'sh1FFFF || data_out == 18'sh20000) sat_seen = 1'b1;
      if (i >= 1800) begin
        v = int'(data_out);
        if (v < 0) v = -v;
        if (v > peak) peak = v;
      end
    end
    check("damp_nosat", {17'b0, sat_seen}, 18'h0);
    check("damp_decay", {17'b0, (peak >= 32768)}, 18'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
